// File: rtl/image_frame_ctrl.sv
// Frame-level sequencer for the pixel-pair image datapath: takes a command,
// restarts the datapath once per frame and checks its line geometry.
`timescale 1ns/1ps
module image_frame_ctrl #(
    parameter int WIDTH      = 768,
    parameter int HEIGHT     = 512,
    parameter int ARM_CYCLES = 4,
    parameter int GAP_CYCLES = 16,
    parameter int TIMEOUT    = 400000,
    parameter int TO_W       = 20
) (
    input  logic       HCLK,
    input  logic       HRESETn,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_value,
    input  logic [7:0] cmd_frames,
    input  logic       abort,
    input  logic       dp_vsync,
    input  logic       dp_hsync,
    input  logic       dp_done,
    output logic       dp_rst_n,
    output logic [1:0] op_sel,
    output logic [7:0] op_value,
    output logic       busy,
    output logic       frame_done,
    output logic       seq_done,
    output logic [7:0] frames_done,
    output logic [9:0] line_cnt,
    output logic       err,
    output logic [1:0] err_code
);
    localparam int PW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(ARM_CYCLES + GAP_CYCLES) + 1;
    localparam logic [PW-1:0] LINE_PAIRS = PW'(WIDTH / 2);

    typedef enum logic [2:0] {IDLE, ARM, RUN, GAP, ERR} state_t;

    state_t          state_reg;
    logic [CW-1:0]   cnt_reg;
    logic [TO_W-1:0] wd_reg;
    logic [PW-1:0]   pair_cnt_reg;
    logic [7:0]      target_reg;
    logic            hsync_d;
    logic            done_d;
    logic            hs_rise;
    logic            len_bad;
    logic            done_rise;
    logic            geom_bad;

    assign cmd_ready = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

    assign hs_rise   = dp_hsync & ~hsync_d;
    assign len_bad   = ~dp_hsync & hsync_d & (pair_cnt_reg != LINE_PAIRS);
    assign done_rise = dp_done & ~done_d;
    // A second VSYNC after lines have started means the frame restarted mid-way.
    assign geom_bad  = len_bad | (dp_vsync & (line_cnt != 10'd0)) |
                       (done_rise & (line_cnt != 10'(HEIGHT)));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hsync_d      <= 1'b0;
            done_d       <= 1'b0;
            pair_cnt_reg <= '0;
        end else begin
            hsync_d <= dp_hsync;
            done_d  <= dp_done;
            if (hs_rise)
                pair_cnt_reg <= PW'(1);
            else if (dp_hsync && pair_cnt_reg != {PW{1'b1}})
                pair_cnt_reg <= pair_cnt_reg + PW'(1);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            wd_reg      <= '0;
            target_reg  <= '0;
            dp_rst_n    <= 1'b0;
            op_sel      <= '0;
            op_value    <= '0;
            frame_done  <= 1'b0;
            seq_done    <= 1'b0;
            frames_done <= '0;
            line_cnt    <= '0;
            err         <= 1'b0;
            err_code    <= '0;
        end else begin
            frame_done <= 1'b0;
            seq_done   <= 1'b0;
            if (abort && state_reg != IDLE) begin
                state_reg <= IDLE;
                dp_rst_n  <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (cmd_valid) begin
                            if (cmd_frames == 8'd0) begin
                                err      <= 1'b1;
                                err_code <= 2'b01;
                            end else begin
                                op_sel      <= cmd_op;
                                op_value    <= cmd_value;
                                target_reg  <= cmd_frames;
                                err         <= 1'b0;
                                err_code    <= 2'b00;
                                frames_done <= '0;
                                line_cnt    <= '0;
                                cnt_reg     <= '0;
                                state_reg   <= ARM;
                            end
                        end
                    end
                    ARM: begin
                        if (cnt_reg == CW'(ARM_CYCLES - 1)) begin
                            state_reg <= RUN;
                            dp_rst_n  <= 1'b1;
                            wd_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    RUN: begin
                        wd_reg <= wd_reg + TO_W'(1);
                        if (hs_rise && line_cnt != 10'h3FF)
                            line_cnt <= line_cnt + 10'd1;
                        if (geom_bad) begin
                            state_reg <= ERR;
                            dp_rst_n  <= 1'b0;
                            err       <= 1'b1;
                            err_code  <= 2'b11;
                        end else if (done_rise) begin
                            frame_done  <= 1'b1;
                            frames_done <= frames_done + 8'd1;
                            if ((frames_done + 8'd1) == target_reg) begin
                                seq_done  <= 1'b1;
                                state_reg <= IDLE;
                                dp_rst_n  <= 1'b0;
                            end else begin
                                state_reg <= GAP;
                                cnt_reg   <= '0;
                            end
                        end else if (wd_reg == TO_W'(TIMEOUT - 1)) begin
                            state_reg <= ERR;
                            dp_rst_n  <= 1'b0;
                            err       <= 1'b1;
                            err_code  <= 2'b10;
                        end
                    end
                    GAP: begin
                        // The last line's HSYNC falls here, one cycle after done.
                        if (len_bad) begin
                            state_reg <= ERR;
                            dp_rst_n  <= 1'b0;
                            err       <= 1'b1;
                            err_code  <= 2'b11;
                        end else if (cnt_reg == CW'(GAP_CYCLES - 1)) begin
                            state_reg <= ARM;
                            dp_rst_n  <= 1'b0;
                            cnt_reg   <= '0;
                            line_cnt  <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + CW'(1);
                        end
                    end
                    ERR: begin
                        state_reg <= IDLE;
                        dp_rst_n  <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                        dp_rst_n  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: doc/image_frame_ctrl.md
Name: image_frame_ctrl

Overview:
- Frame-level sequencer for the pixel-pair image reader/processing datapath.
- Accepts an operation command (op select, op value, frame count) by valid/ready handshake and latches the configuration.
- Restarts the datapath once per frame via its reset and monitors its VSYNC/HSYNC/done outputs; checks line count and line length, and runs a watchdog.
- Sits between the host/CSR layer and the image datapath.

Parameters:
- WIDTH, 768, image width in pixels; one line = WIDTH/2 HSYNC-high cycles.
- HEIGHT, 512, lines per frame.
- ARM_CYCLES, 4, cycles the datapath reset is held low before each frame.
- GAP_CYCLES, 16, idle cycles between consecutive frames.
- TIMEOUT, 400000, maximum RUN cycles before a timeout error.
- TO_W, 20, watchdog counter width.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready; high only in IDLE
- cmd_op  in  2  00 bypass, 01 brightness, 10 invert, 11 threshold
- cmd_value  in  8  brightness value or threshold
- cmd_frames  in  8  frames to run; 0 is illegal
- abort  in  1  abort sequence
- dp_vsync  in  1  datapath VSYNC
- dp_hsync  in  1  datapath HSYNC (high during pixel-pair data)
- dp_done  in  1  datapath frame done flag
- dp_rst_n  out  1  datapath reset, active low
- op_sel  out  2  latched cmd_op
- op_value  out  8  latched cmd_value
- busy  out  1  state not IDLE
- frame_done  out  1  one-cycle pulse per completed frame
- seq_done  out  1  one-cycle pulse when all frames are complete
- frames_done  out  8  completed frames in the current sequence
- line_cnt  out  10  lines seen in the current frame
- err  out  1  sticky error flag
- err_code  out  2  00 none, 01 bad command, 10 timeout, 11 geometry

Behaviour:
- Reset values: all outputs 0, cmd_ready=1, dp_rst_n=0, state IDLE.
- Reset mid-operation returns to IDLE immediately.
- All outputs are registered except cmd_ready and busy, which are decoded from state.
- States are IDLE, ARM, RUN, GAP and ERR.
- dp_rst_n is 1 only in RUN and GAP.
- IDLE:
  - Handshake is cmd_valid & cmd_ready.
  - If cmd_frames==0: stay in IDLE, err=1, err_code=01, op_sel/op_value unchanged.
  - Otherwise: latch op_sel, op_value and the target count; clear err/err_code, frames_done and line_cnt; go to ARM next cycle.
  - op_sel/op_value hold until the next accepted command.
- ARM:
  - Counter runs ARM_CYCLES cycles with dp_rst_n=0; line_cnt is cleared on entry.
  - Then go to RUN.
  - Watchdog is cleared on entry to RUN.
- RUN:
  - hsync_d is registered. A rising edge (dp_hsync & ~hsync_d) increments line_cnt, saturating at 1023.
  - pair_cnt counts HSYNC-high cycles and is cleared on each rising edge.
  - On a falling edge, if pair_cnt != WIDTH/2, go to ERR with code 11.
  - On dp_done rising edge:
    - If line_cnt != HEIGHT, go to ERR with code 11.
    - Otherwise increment frames_done and pulse frame_done.
    - If frames_done+1 == target, also pulse seq_done (same cycle) and go to IDLE; else go to GAP.
  - Watchdog increments every RUN cycle. On reaching TIMEOUT, go to ERR with code 10.
- GAP:
  - Runs GAP_CYCLES cycles, then ARM.
  - The line-length check stays active in GAP, because the last HSYNC falling edge follows dp_done by one cycle.
- ERR: err=1, err_code set, dp_rst_n=0; go to IDLE next cycle. err/err_code stay sticky until the next accepted command.
- abort:
  - In any non-IDLE state, go to IDLE next cycle. No error, no pulses; frames_done is retained.
  - abort in IDLE is ignored.
  - abort and cmd_valid in the same IDLE cycle: the command is accepted.
- Simultaneous events in the same cycle:
  - dp_done with timeout: done wins.
  - dp_done with an HSYNC falling edge and wrong length: error wins.
  - abort wins over everything except reset.
- dp_vsync is monitored only. A dp_vsync high in RUN after line_cnt>0 is a geometry error (code 11).

Test Plan:
- WIDTH=8, HEIGHT=4, behavioural datapath model; cmd_frames=1, op=11, value=100 -> op_sel=3, op_value=100; dp_rst_n low 4 cycles; line_cnt=4; frame_done and seq_done pulse together; frames_done=1; err=0.
- cmd_frames=3 -> three ARM/RUN cycles with 16-cycle GAPs; frame_done pulses 3x; seq_done once; frames_done=3.
- Model emits a 3-pair line -> ERR code 11, dp_rst_n=0, back to IDLE; err stays 1 until the next good command clears it.
- TIMEOUT=50, model never asserts done -> ERR code 10 exactly 50 cycles after entering RUN.
- cmd_frames=0 -> err_code=01, state stays IDLE, op_sel unchanged. abort mid-RUN of frame 2 -> IDLE next cycle, frames_done=1, no seq_done.
- HRESETn pulsed low mid-RUN -> all outputs return to reset values asynchronously; cmd_ready=1 after release.
